// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - ALU op codes, FSM state encoding and B-operand conditioning for alu_arbiter
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_NOT = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_OR  = 3'd4;
  localparam logic [2:0] ALU_XOR = 3'd5;
  localparam logic [2:0] ALU_SLT = 3'd6;
  localparam logic [2:0] ALU_EQ  = 3'd7;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // The shared ALU only adds, so subtract-style ops get B pre-negated (0x8000_0000 maps to itself).
  function automatic logic [XLEN-1:0] cond_b(input logic [2:0] op, input logic [XLEN-1:0] b);
    return (op == ALU_SUB || op == ALU_SLT) ? (~b + 32'd1) : b;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester and response channels of alu_arbiter
interface alu_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*3-1:0]  req_op;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_res;
  logic               rsp_cout;
  logic               rsp_ovf;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_res, rsp_cout, rsp_ovf
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_res, rsp_cout, rsp_ovf
  );
endinterface

// File: rtl/alu_arbiter_rr_pick.sv
// rtl/alu_arbiter_rr_pick.sv - combinational round-robin picker, searching rr_ptr+1 .. rr_ptr+NREQ
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] grant_oh,
  output logic [IDW-1:0]  grant_idx,
  output logic            grant_any
);

  logic [IDW-1:0] cand;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    // Walk from the farthest candidate back to the nearest so the nearest valid one wins.
    for (int k = NREQ; k >= 1; k--) begin
      cand = IDW'((int'(rr_ptr) + k) % NREQ);
      if (req_valid[cand]) begin
        grant_idx = cand;
        grant_any = 1'b1;
      end
    end
    if (grant_any) grant_oh[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one external ALU, one op in flight (IDLE->EXEC->RESP)
// Optional per-requester grant counters on stat_cnt when ALU_ARB_STATS_EN is defined.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  alu_arbiter_if.slave    bus,
  output logic [2:0]      alu_fun_sel,
  output logic [XLEN-1:0] alu_in_a,
  output logic [XLEN-1:0] alu_in_b,
  input  logic [XLEN-1:0] alu_res,
  input  logic            alu_cout,
  input  logic            alu_ovf,
  output logic            busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0] stat_cnt
`endif
);

  logic [1:0]      state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [NREQ-1:0] grant_oh;
  logic [IDW-1:0]  grant_idx;
  logic            grant_any;
  logic [31:0]     gsel;
  logic            req_hs;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign gsel   = {{(32-IDW){1'b0}}, grant_idx};
  assign req_hs = (state_q == IDLE) && grant_any;

  // rst is folded in so ready stays low for the whole reset pulse, not just after the first edge.
  assign bus.req_ready = (state_q == IDLE && !rst) ? grant_oh : '0;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_valid_d = rsp_valid_q;
    res_d       = res_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    case (state_q)
      IDLE: begin
        if (req_hs) begin
          op_d     = bus.req_op[gsel*3 +: 3];
          a_d      = bus.req_a[gsel*32 +: 32];
          b_d      = cond_b(bus.req_op[gsel*3 +: 3], bus.req_b[gsel*32 +: 32]);
          rr_ptr_d = grant_idx;
          id_d     = grant_idx;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        res_d       = alu_res;
        cout_d      = alu_cout;
        ovf_d       = alu_ovf;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= IDW'(NREQ - 1);
      id_q        <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      res_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_valid_q <= rsp_valid_d;
      res_q       <= res_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign alu_fun_sel  = op_q;
  assign alu_in_a     = a_q;
  assign alu_in_b     = b_q;
  assign busy         = (state_q != IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_res   = res_q;
  assign bus.rsp_cout  = cout_q;
  assign bus.rsp_ovf   = ovf_q;

`ifdef ALU_ARB_STATS_EN
  logic [NREQ*16-1:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if (req_hs && stat_q[gsel*16 +: 16] != 16'hFFFF)
      stat_d[gsel*16 +: 16] = stat_q[gsel*16 +: 16] + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stat_q <= '0;
    else     stat_q <= stat_d;
  end

  assign stat_cnt = stat_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized and directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] inb;
    logic [31:0] res;
    logic        cout;
    logic        ovf;
    int          id;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  alu_fun_sel;
  logic [31:0] alu_in_a, alu_in_b, alu_res;
  logic        alu_cout, alu_ovf, busy;
`ifdef ALU_ARB_STATS_EN
  logic [NREQ*16-1:0] stat_cnt;
`endif

  alu_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .alu_fun_sel (alu_fun_sel),
    .alu_in_a    (alu_in_a),
    .alu_in_b    (alu_in_b),
    .alu_res     (alu_res),
    .alu_cout    (alu_cout),
    .alu_ovf     (alu_ovf),
    .busy        (busy)
`ifdef ALU_ARB_STATS_EN
    ,
    .stat_cnt    (stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Shared ALU: adds A to the already-conditioned B; SLT recovers B by negating again.
  function automatic logic [33:0] alu_fn(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, v;
    s = {1'b0, x} + {1'b0, y};
    r = '0; c = 1'b0; v = 1'b0;
    case (f)
      3'd0, 3'd1: begin r = s[31:0]; c = s[32]; v = (x[31] == y[31]) && (r[31] != x[31]); end
      3'd2: r = ~x;
      3'd3: r = x & y;
      3'd4: r = x | y;
      3'd5: r = x ^ y;
      3'd6: r = {31'b0, $signed(x) < $signed(32'h0 - y)};
      default: r = {31'b0, x == y};
    endcase
    return {r, c, v};
  endfunction

  always_comb {alu_res, alu_cout, alu_ovf} = alu_fn(alu_fun_sel, alu_in_a, alu_in_b);

  // Reference: what a requester should get back, from the op's arithmetic meaning.
  function automatic exp_t exp_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int id);
    exp_t e;
    longint sa;
    logic [32:0] s;
    e.op = op; e.a = a; e.id = id; e.cout = 1'b0; e.ovf = 1'b0;
    e.inb = (op == 3'd1 || op == 3'd6) ? (32'h0 - b) : b;
    case (op)
      3'd0: e.res = a + b;
      3'd1: e.res = a - b;
      3'd2: e.res = ~a;
      3'd3: e.res = a & b;
      3'd4: e.res = a | b;
      3'd5: e.res = a ^ b;
      3'd6: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: e.res = (a == b) ? 32'd1 : 32'd0;
    endcase
    if (op == 3'd0 || op == 3'd1) begin
      s = {1'b0, a} + {1'b0, e.inb};
      e.cout = s[32];
      sa = longint'($signed(a)) + longint'($signed(e.inb));
      e.ovf = (sa > 64'sd2147483647) || (sa < -64'sd2147483648);
    end
    return e;
  endfunction

  int   errors = 0;
  int   checks = 0;
  int   phase  = 0;
  int   last   = NREQ - 1;
  int   gnt    = -1;
  int   mode   = 0;
  int   stat_model [NREQ];
  int   dut_ids [$];
  exp_t cur;
  bit          lit_on = 0, lit_inb_on = 0;
  logic [31:0] lit_res, lit_inb;
  logic        lit_cout, lit_ovf;
  int          lit_id;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic int pick();
    for (int k = 1; k <= NREQ; k++)
      if (bus.req_valid[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req_op[3*i +: 3] = op;
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic check_all();
    int g;
    logic [3:0] er;
    if (rst) begin
      chk("rst_ready", bus.req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
    end else if (phase == 0) begin
      g = pick();
      er = (g >= 0) ? 4'(1 << g) : 4'd0;
      chk("idle_ready", bus.req_ready, er);
      chk("idle_busy", busy, 0);
      chk("idle_rsp_valid", bus.rsp_valid, 0);
    end else if (phase == 1) begin
      chk("exec_ready", bus.req_ready, 0);
      chk("exec_busy", busy, 1);
      chk("exec_rsp_valid", bus.rsp_valid, 0);
      chk("exec_fun_sel", alu_fun_sel, cur.op);
      chk("exec_in_a", alu_in_a, cur.a);
      chk("exec_in_b", alu_in_b, cur.inb);
      if (lit_inb_on) begin chk("lit_in_b", alu_in_b, lit_inb); lit_inb_on = 0; end
    end else begin
      chk("resp_ready", bus.req_ready, 0);
      chk("resp_busy", busy, 1);
      chk("resp_valid", bus.rsp_valid, 1);
      chk("resp_id", bus.rsp_id, cur.id);
      chk("resp_res", bus.rsp_res, cur.res);
      chk("resp_cout", bus.rsp_cout, cur.cout);
      chk("resp_ovf", bus.rsp_ovf, cur.ovf);
      if (lit_on) begin
        chk("lit_id", bus.rsp_id, lit_id);
        chk("lit_res", bus.rsp_res, lit_res);
        chk("lit_cout", bus.rsp_cout, lit_cout);
        chk("lit_ovf", bus.rsp_ovf, lit_ovf);
        lit_on = 0;
      end
      if (bus.rsp_valid && bus.rsp_ready) dut_ids.push_back(int'(bus.rsp_id));
    end
`ifdef ALU_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) chk("stat_cnt", stat_cnt[16*i +: 16], stat_model[i]);
`endif
  endtask

  task automatic advance_model();
    int g;
    gnt = -1;
    if (rst) begin
      phase = 0; last = NREQ - 1;
      for (int i = 0; i < NREQ; i++) stat_model[i] = 0;
      return;
    end
    case (phase)
      0: begin
        g = pick();
        if (g >= 0) begin
          cur = exp_of(bus.req_op[3*g +: 3], bus.req_a[32*g +: 32], bus.req_b[32*g +: 32], g);
          last = g; gnt = g; phase = 1;
          if (stat_model[g] < 65535) stat_model[g]++;
        end
      end
      1: phase = 2;
      default: if (bus.rsp_ready) phase = 0;
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    advance_model();
    @(posedge clk);
    #1;
    if (gnt >= 0) begin
      if (mode == 1) set_req(gnt, 3'($urandom), rnd_operand(), rnd_operand());
      else bus.req_valid[gnt] = 1'b0;
    end
    if (mode == 2) begin
      for (int i = 0; i < NREQ; i++)
        if (!bus.req_valid[i] && ($urandom % 3) == 0)
          set_req(i, 3'($urandom), rnd_operand(), rnd_operand());
      bus.rsp_ready = ($urandom % 4) != 0;
    end
  endtask

  task automatic expect_lit(input int id, input logic [31:0] res, input logic c, input logic v, input logic [31:0] inb);
    lit_on = 1; lit_id = id; lit_res = res; lit_cout = c; lit_ovf = v;
    lit_inb_on = 1; lit_inb = inb;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.req_valid = '0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) stat_model[i] = 0;
    step(); step();
    chk("reset_fun_sel", alu_fun_sel, 0);
    chk("reset_in_a", alu_in_a, 0);
    chk("reset_in_b", alu_in_b, 0);
    chk("reset_rsp_id", bus.rsp_id, 0);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;

    set_req(0, 3'd0, 32'd5, 32'd7);
    expect_lit(0, 32'd12, 1'b0, 1'b0, 32'd7);
    repeat (4) step();
    chk("t1_seen", lit_on, 0);

    set_req(1, 3'd1, 32'd3, 32'd5);
    expect_lit(1, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'hFFFF_FFFB);
    repeat (4) step();
    chk("t2_seen", lit_on, 0);

    set_req(2, 3'd6, 32'hFFFF_FFFF, 32'd1);
    expect_lit(2, 32'd1, 1'b0, 1'b0, 32'hFFFF_FFFF);
    repeat (4) step();
    chk("t3a_seen", lit_on, 0);
    set_req(2, 3'd6, 32'h7FFF_FFFF, 32'h8000_0000);
    expect_lit(2, 32'd0, 1'b0, 1'b0, 32'h8000_0000);
    repeat (4) step();
    chk("t3b_seen", lit_on | lit_inb_on, 0);

    rst = 1'b1; step(); rst = 1'b0;
    dut_ids.delete();
    mode = 1;
    for (int i = 0; i < NREQ; i++) set_req(i, 3'($urandom), rnd_operand(), rnd_operand());
    for (int n = 0; n < 100 && dut_ids.size() < 6; n++) step();
    for (int n = 0; n < 10 && phase != 2; n++) step();
    chk("t5_in_resp", phase, 2);
    bus.rsp_ready = 1'b0;
    repeat (5) step();
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 100 && dut_ids.size() < 12; n++) step();
    chk("t4_count", dut_ids.size() >= 12, 1);
    for (int k = 0; k < 12 && k < dut_ids.size(); k++) chk("rr_order", dut_ids[k], k % NREQ);

    mode = 0;
    bus.req_valid = '0;
    for (int n = 0; n < 10 && phase != 0; n++) step();
    set_req(3, 3'd0, 32'd1, 32'd2);
    for (int n = 0; n < 10 && phase != 1; n++) step();
    chk("t6_in_exec", busy, 1);
    rst = 1'b1;
    dut_ids.delete();
    step();
    rst = 1'b0;
    set_req(3, 3'd4, 32'hF0, 32'h0F);
    set_req(0, 3'd5, 32'hFF, 32'h0F);
    repeat (6) step();
    chk("t6_rsp_count", dut_ids.size() >= 1, 1);
    if (dut_ids.size() >= 1) chk("t6_first_id", dut_ids[0], 0);

    mode = 2;
    repeat (3000) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
